// File: rtl/sram_1w1r_tiled_pkg.sv
// rtl/sram_1w1r_tiled_pkg.sv - shared types and geometry helpers for the tiled 1W1R SRAM wrapper
package sram_tiled_pkg;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  function automatic int calc_banks(input int addr_w, input int macro_depth);
    return (1 << addr_w) / macro_depth;
  endfunction

  function automatic int calc_cols(input int data_w, input int macro_width);
    return data_w / macro_width;
  endfunction

  function automatic int calc_gran(input int data_w, input int mask_w);
    return data_w / mask_w;
  endfunction

  function automatic int calc_row_w(input int macro_depth);
    return $clog2(macro_depth);
  endfunction

  function automatic int calc_bank_w(input int addr_w, input int macro_depth);
    return addr_w - $clog2(macro_depth);
  endfunction

  // Index of the first logical mask bit that lands in column col.
  function automatic int col_mask_lo(input int col, input int macro_width, input int gran);
    return (col * macro_width) / gran;
  endfunction

endpackage

// File: rtl/sram_1w1r_tiled_macro.sv
// rtl/sram_1w1r_tiled_macro.sv - behavioural stand-in for the OpenRAM 1w1r hard macro
module sram_macro_1w1r #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
) (
  input  logic              clk0,
  input  logic              csb0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] din0,
  input  logic [MASK_W-1:0] wmask0,
  input  logic              clk1,
  input  logic              csb1,
  input  logic [ADDR_W-1:0] addr1,
  output logic [DATA_W-1:0] dout1
);

  localparam int G = DATA_W / MASK_W;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk0) begin
    if (!csb0) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (wmask0[i]) mem[addr0][i*G +: G] <= din0[i*G +: G];
      end
    end
  end

  // Granules being written on the same row in the same cycle come back corrupted.
  always_ff @(posedge clk1) begin
    if (!csb1) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (!csb0 && addr0 == addr1 && wmask0[i]) dout1[i*G +: G] <= {G{1'bx}};
        else                                      dout1[i*G +: G] <= mem[addr1][i*G +: G];
      end
    end
  end

endmodule

// File: rtl/sram_1w1r_tiled.sv
// rtl/sram_1w1r_tiled.sv - N x M tiled 1W1R SRAM with zero-init sweep and read-during-write merge
module sram_1w1r_tiled
  import sram_tiled_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 64,
  parameter int MASK_W      = 8,
  parameter int MACRO_DEPTH = 128,
  parameter int MACRO_WIDTH = 32,
  parameter int INIT_EN     = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              W0_en,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic [DATA_W-1:0] W0_data,
  input  logic [MASK_W-1:0] W0_mask,
  input  logic              R0_en,
  input  logic [ADDR_W-1:0] R0_addr,
  output logic [DATA_W-1:0] R0_data,
  output logic              R0_valid,
  output logic              ready
);

  localparam int BANKS  = calc_banks(ADDR_W, MACRO_DEPTH);
  localparam int COLS   = calc_cols(DATA_W, MACRO_WIDTH);
  localparam int G      = calc_gran(DATA_W, MASK_W);
  localparam int ROW_W  = calc_row_w(MACRO_DEPTH);
  localparam int BANK_W = calc_bank_w(ADDR_W, MACRO_DEPTH);
  localparam int BK_W   = (BANK_W > 0) ? BANK_W : 1;
  localparam int CMW    = MACRO_WIDTH / G;

  state_t                        state;
  logic [ROW_W-1:0]              init_cnt;
  logic [BANKS-1:0]              csb0_vec, csb1_vec;
  logic [ROW_W-1:0]              row0, row1;
  logic [DATA_W-1:0]             din;
  logic [MASK_W-1:0]             wmask;
  logic [BK_W-1:0]               w_bank, r_bank, r_bank_q;
  logic                          w_fire, r_fire, hit;
  logic                          rd_valid_q, hit_q;
  logic [DATA_W-1:0]             wdata_q, hold_q, rd_raw, merged;
  logic [MASK_W-1:0]             wmask_q;
  logic [BANKS-1:0][DATA_W-1:0]  bank_dout;

  assign w_bank = BK_W'(W0_addr >> ROW_W);
  assign r_bank = BK_W'(R0_addr >> ROW_W);
  assign row1   = R0_addr[ROW_W-1:0];
  assign w_fire = ready && W0_en && (|W0_mask);
  assign r_fire = ready && R0_en;
  assign hit    = w_fire && r_fire && (W0_addr == R0_addr);

  // The init sweep owns the write port and hits the same row of every bank.
  always_comb begin
    row0     = W0_addr[ROW_W-1:0];
    din      = W0_data;
    wmask    = W0_mask;
    csb0_vec = '1;
    csb1_vec = '1;
    if (state == ST_INIT) begin
      row0     = init_cnt;
      din      = '0;
      wmask    = '1;
      csb0_vec = '0;
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        if (w_fire && w_bank == BK_W'(b)) csb0_vec[b] = 1'b0;
      end
    end
    for (int b = 0; b < BANKS; b++) begin
      if (r_fire && r_bank == BK_W'(b)) csb1_vec[b] = 1'b0;
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sram_macro_1w1r #(
        .ADDR_W (ROW_W),
        .DATA_W (MACRO_WIDTH),
        .MASK_W (CMW)
      ) u_macro (
        .clk0   (clock),
        .csb0   (csb0_vec[b]),
        .addr0  (row0),
        .din0   (din[c*MACRO_WIDTH +: MACRO_WIDTH]),
        .wmask0 (wmask[col_mask_lo(c, MACRO_WIDTH, G) +: CMW]),
        .clk1   (clock),
        .csb1   (csb1_vec[b]),
        .addr1  (row1),
        .dout1  (bank_dout[b][c*MACRO_WIDTH +: MACRO_WIDTH])
      );
    end
  end

  always_comb begin
    rd_raw = bank_dout[r_bank_q];
    merged = rd_raw;
    for (int i = 0; i < MASK_W; i++) begin
      if (hit_q && wmask_q[i]) merged[i*G +: G] = wdata_q[i*G +: G];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= (INIT_EN != 0) ? ST_INIT : ST_READY;
      init_cnt   <= '0;
      ready      <= 1'b0;
      rd_valid_q <= 1'b0;
      r_bank_q   <= '0;
      hit_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      hold_q     <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + ROW_W'(1);
          if (init_cnt == ROW_W'(MACRO_DEPTH - 1)) begin
            state <= ST_READY;
            ready <= 1'b1;
          end
        end
        ST_READY: ready <= 1'b1;
      endcase
      rd_valid_q <= r_fire;
      hit_q      <= hit;
      if (r_fire) r_bank_q <= r_bank;
      if (hit) begin
        wdata_q <= W0_data;
        wmask_q <= W0_mask;
      end
      if (rd_valid_q) hold_q <= merged;
    end
  end

  // Read data is the macro's registered dout in the valid cycle, then the held copy.
  assign R0_data  = rd_valid_q ? merged : hold_q;
  assign R0_valid = rd_valid_q;

endmodule

// File: tb/tb_sram_1w1r_tiled.sv
// tb/tb_sram_1w1r_tiled.sv - directed table-driven bench for sram_1w1r_tiled
module tb_sram_1w1r_tiled;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        W0_en = 1'b0;
  logic [8:0]  W0_addr = '0;
  logic [63:0] W0_data = '0;
  logic [7:0]  W0_mask = '0;
  logic        R0_en = 1'b0;
  logic [8:0]  R0_addr = '0;
  logic [63:0] R0_data;
  logic        R0_valid;
  logic        ready;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [8:0]  addr;
    logic [63:0] data;
    logic [7:0]  mask;
    logic [63:0] exp;
  } vec_t;

  vec_t rdw_tab [4];
  vec_t seq_tab [4];

  sram_1w1r_tiled dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .W0_en    (W0_en),
    .W0_addr  (W0_addr),
    .W0_data  (W0_data),
    .W0_mask  (W0_mask),
    .R0_en    (R0_en),
    .R0_addr  (R0_addr),
    .R0_data  (R0_data),
    .R0_valid (R0_valid),
    .ready    (ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  task automatic idle();
    W0_en = 1'b0;
    W0_mask = '0;
    R0_en = 1'b0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [63:0] d, input logic [7:0] m);
    W0_en = 1'b1; W0_addr = a; W0_data = d; W0_mask = m;
    @(negedge clock);
    idle();
  endtask

  task automatic rd_check(input string name, input logic [8:0] a, input logic [63:0] exp);
    R0_en = 1'b1; R0_addr = a;
    @(negedge clock);
    idle();
    check({name, "_valid"}, 64'(R0_valid), 64'd1);
    check({name, "_data"}, R0_data, exp);
  endtask

  // Counts edges from reset release until ready; any R0_valid meanwhile is an error.
  task automatic wait_ready(input string name);
    int k;
    logic seen_valid;
    k = 0;
    seen_valid = 1'b0;
    while (!ready && k < 300) begin
      @(negedge clock);
      k++;
      if (R0_valid) seen_valid = 1'b1;
      if (k == 20) idle();
    end
    check({name, "_edges"}, 64'(k), 64'd128);
    check({name, "_no_valid"}, 64'(seen_valid), 64'd0);
  endtask

  initial begin
    rdw_tab[0] = '{9'h1AB, 64'hFF00000000000000, 8'h80, 64'hFF23456789ABCDEF};
    rdw_tab[1] = '{9'h1AB, 64'h00000000000000EE, 8'h01, 64'hFF23456789ABCDEE};
    rdw_tab[2] = '{9'h1AB, 64'hFFFFFFFFFFFFFFFF, 8'h00, 64'hFF23456789ABCDEE};
    rdw_tab[3] = '{9'h1AB, 64'h0000AABBCCDD0000, 8'h3C, 64'hFF23AABBCCDDCDEE};
    seq_tab[0] = '{9'h000, 64'h0000000000000000, 8'hFF, 64'h0000000000000000};
    seq_tab[1] = '{9'h080, 64'h0000000000000080, 8'hFF, 64'h0000000000000080};
    seq_tab[2] = '{9'h100, 64'h0000000000000100, 8'hFF, 64'h0000000000000100};
    seq_tab[3] = '{9'h180, 64'h0000000000000180, 8'hFF, 64'h0000000000000180};

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_valid", 64'(R0_valid), 64'd0);
    check("rst_data", R0_data, 64'd0);

    // Release, then poke both ports during INIT; they must be ignored.
    reset_n = 1'b1;
    W0_en = 1'b1; W0_addr = 9'h033; W0_data = '1; W0_mask = 8'hFF;
    R0_en = 1'b1; R0_addr = 9'h033;
    wait_ready("init");
    rd_check("rd_1ff", 9'h1FF, 64'd0);
    rd_check("rd_033", 9'h033, 64'd0);

    // Full write to bank 1 only, then read back.
    W0_en = 1'b1; W0_addr = 9'h085; W0_data = 64'h1122334455667788; W0_mask = 8'hFF;
    #1;
    check("wr_csb0", 64'(dut.csb0_vec), 64'h0D);
    check("wr_csb1", 64'(dut.csb1_vec), 64'h0F);
    @(negedge clock);
    idle();
    R0_en = 1'b1; R0_addr = 9'h085;
    #1;
    check("rd_csb1", 64'(dut.csb1_vec), 64'h0D);
    check("rd_csb0", 64'(dut.csb0_vec), 64'h0F);
    @(negedge clock);
    idle();
    check("rd_085_valid", 64'(R0_valid), 64'd1);
    check("rd_085_data", R0_data, 64'h1122334455667788);

    // Same-cycle write+read, partial mask.
    W0_en = 1'b1; W0_addr = 9'h085; W0_data = 64'hAAAAAAAAAAAAAAAA; W0_mask = 8'h0F;
    R0_en = 1'b1; R0_addr = 9'h085;
    @(negedge clock);
    idle();
    check("rdw_valid", 64'(R0_valid), 64'd1);
    check("rdw_data", R0_data, 64'h11223344AAAAAAAA);
    @(negedge clock);
    check("hold_valid", 64'(R0_valid), 64'd0);
    check("hold_data", R0_data, 64'h11223344AAAAAAAA);
    rd_check("rdw_after", 9'h085, 64'h11223344AAAAAAAA);

    // Cumulative read-during-write merges on one word.
    wr(9'h1AB, 64'h0123456789ABCDEF, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      W0_en = 1'b1; W0_addr = rdw_tab[i].addr; W0_data = rdw_tab[i].data; W0_mask = rdw_tab[i].mask;
      R0_en = 1'b1; R0_addr = rdw_tab[i].addr;
      @(negedge clock);
      idle();
      check($sformatf("rdw_tab%0d", i), R0_data, rdw_tab[i].exp);
      @(negedge clock);
    end
    rd_check("rdw_tab_final", 9'h1AB, 64'hFF23AABBCCDDCDEE);

    // Back-to-back writes then reads across all four banks.
    for (int i = 0; i < 4; i++) begin
      W0_en = 1'b1; W0_addr = seq_tab[i].addr; W0_data = seq_tab[i].data; W0_mask = seq_tab[i].mask;
      @(negedge clock);
    end
    idle();
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        R0_en = 1'b1; R0_addr = seq_tab[i].addr;
      end else begin
        idle();
      end
      @(negedge clock);
      if (i < 4) begin
        check($sformatf("seq%0d_valid", i), 64'(R0_valid), 64'd1);
        check($sformatf("seq%0d_data", i), R0_data, seq_tab[i].exp);
      end
    end
    repeat (2) @(negedge clock);
    check("seq_idle_valid", 64'(R0_valid), 64'd0);
    check("seq_idle_data", R0_data, 64'h180);

    // Reset clears held data at once, then reset again mid-INIT.
    reset_n = 1'b0;
    #1;
    check("rst2_data", R0_data, 64'd0);
    check("rst2_ready", 64'(ready), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (60) @(negedge clock);
    check("mid_init_cnt", 64'(dut.init_cnt), 64'd60);
    reset_n = 1'b0;
    #1;
    check("mid_rst_cnt", 64'(dut.init_cnt), 64'd0);
    check("mid_rst_ready", 64'(ready), 64'd0);
    check("mid_rst_valid", 64'(R0_valid), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_ready("reinit");
    rd_check("reinit_085", 9'h085, 64'd0);
    rd_check("reinit_180", 9'h180, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_1w1r_tiled.md
Name: sram_1w1r_tiled

Overview:
Parametrised 1W1R SRAM wrapper, the successor to the single-macro wrappers. It tiles N x M OpenRAM 1w1r macros in depth (banks) and width (columns) to build arbitrary logical memories. Adds three functions:
- post-reset zero-initialisation sweep
- same-cycle read-during-write forwarding with byte-mask merge
- registered, held read data

It sits between Chisel-generated memory ports (W0_*/R0_*) and the hard macros.

Parameters:
ADDR_W, 9, logical address width; logical depth = 2**ADDR_W
DATA_W, 64, logical word width
MASK_W, 8, write-mask bits; granule G = DATA_W/MASK_W; DATA_W % MASK_W == 0
MACRO_DEPTH, 128, entries per macro (power of 2, <= 2**ADDR_W)
MACRO_WIDTH, 32, bits per macro; DATA_W % MACRO_WIDTH == 0; MACRO_WIDTH % G == 0
INIT_EN, 1, 1 = run zero-init sweep after reset; 0 = ready immediately after reset

Ports:
clock  in  1  single clock for all macros and logic
reset_n  in  1  asynchronous active-low reset
W0_en  in  1  write request
W0_addr  in  ADDR_W  write address
W0_data  in  DATA_W  write data
W0_mask  in  MASK_W  per-granule write enable; bit i covers data[i*G +: G]
R0_en  in  1  read request
R0_addr  in  ADDR_W  read address
R0_data  out  DATA_W  read data, registered, held between reads
R0_valid  out  1  one-cycle pulse: R0_data updated this cycle
ready  out  1  init complete; requests are accepted only when high

Behaviour:
- Reset, asynchronous, active-low:
  - ready=0, R0_valid=0, R0_data=0
  - FSM goes to INIT if INIT_EN=1, else to READY
  - Write and read pipeline registers cleared.
- Derived sizes:
  - BANKS = 2**ADDR_W/MACRO_DEPTH; COLS = DATA_W/MACRO_WIDTH
  - Bank index = addr[ADDR_W-1 : log2(MACRO_DEPTH)]; row = low bits.
  - With BANKS=1 the bank field is empty.
- FSM states:
  - INIT: a counter sweeps 0..MACRO_DEPTH-1. Every cycle it writes zero with full mask into that row of all banks and columns in parallel. When count == MACRO_DEPTH-1, the next state is READY.
  - READY: ready=1. The FSM stays here until reset.
  - Init takes exactly MACRO_DEPTH cycles after reset deassertion, and ready rises on the following cycle.
- Reset asserted mid-INIT: the counter restarts from 0 after release.
- While ready=0, W0_en and R0_en are ignored. Writes are dropped, R0_valid stays 0 and R0_data holds its value.
- Write:
  - In the W0_en cycle, only the addressed bank's macros get csb0=0.
  - Each column gets wmask0 = the slice of W0_mask covering its bits.
  - If W0_mask == 0, no macro is enabled.
- Read:
  - In the R0_en cycle t, only the addressed bank's csb1=0.
  - The bank index is registered, and the column outputs of that bank are muxed in cycle t+1.
  - R0_data is updated from a register in cycle t+1 (effective latency 1), with R0_valid=1 in t+1.
  - Without R0_en, R0_data holds its previous value; the macro dout is never passed through unregistered.
- Read-during-write, same cycle, same address, both enabled:
  - The macro read result is treated as undefined.
  - In t+1, R0_data granule i = W0_data granule i if W0_mask[i], else the old stored granule from the macro read.
  - The wrapper registers the write data, the mask and a hit flag to do the merge.
- Same-cycle read and write to different addresses or banks: independent, with no interaction.
- A write in cycle t followed by a read of the same address in t+1 returns the new data; the macro provides this natively.
- Back-to-back reads: one result per cycle, fully pipelined.

Decomposition:
- Package sram_tiled_pkg:
  - FSM state enum (INIT, READY)
  - Functions computing BANKS, COLS, G and the bank/row field widths
  - Column mask-slice helper
- One sub-module, sram_macro_1w1r: a behavioural model of the OpenRAM 1w1r macro.
  - Ports: clk0/csb0/addr0/din0/wmask0 and clk1/csb1/addr1/dout1.
  - dout1 is registered with 1-cycle latency.
  - dout1 is set to X on a same-cycle same-row collision.
  - It is replaced by the real macro at synthesis.
- Top level holds: the generate grid, the FSM and counter, bank decode, and the forwarding merge and output register.

Test Plan:
1. Release reset_n with defaults (4 banks x 2 cols) -> ready=0 for 128 cycles, ready=1 on cycle 129; read addr 0x1FF -> R0_data=0 and R0_valid=1 one cycle later.
2. Write addr 0x085, data 0x1122334455667788, mask 0xFF; next cycle read 0x085 -> R0_data=0x1122334455667788 one cycle after the read; no other bank enabled (check csb per macro).
3. Stored 0x1122334455667788; same cycle write 0x085, data 0xAAAAAAAAAAAAAAAA, mask 0x0F, plus read 0x085 -> R0_data=0x11223344AAAAAAAA; a subsequent read returns the same value.
4. Write/read while ready=0 (during INIT) -> no R0_valid; after ready, the address reads 0.
5. Assert reset_n at INIT count 60 -> outputs go to reset values immediately; after release ready rises exactly 129 cycles later.
6. Reads at 0x000, 0x080, 0x100, 0x180 on 4 consecutive cycles, each pre-written with its address value -> 4 consecutive R0_valid pulses with matching data; idle afterwards -> R0_data holds 0x180.
